// File: rtl/entry_park_pkg.sv
// Shared constants for the parking-slot allocator.
package entry_park_pkg;
    localparam int SLOTS_DEFAULT = 8;
    localparam int IDX_W_DEFAULT = 3;
endpackage

// File: rtl/free_slot_finder.sv
// Combinational priority encoder: lowest-index zero bit of the occupancy map.
module free_slot_finder
    import entry_park_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic [SLOTS-1:0] occupancy,
    output logic [IDX_W-1:0] free_idx,
    output logic             found
);
    // Scan high to low so the last hit, the lowest free slot, wins.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                free_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/entry_park.sv
// Gate-entry slot allocator: assigns the lowest free slot on each entry
// rising edge and reports registered occupancy status.
module entry_park
    import entry_park_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry,
    input  logic [SLOTS-1:0] parking_capacity,
    output logic [IDX_W-1:0] park_number,
    output logic             park_valid,
    output logic             park_full,
    output logic [IDX_W:0]   free_count
);
    logic             entry_q, entry_d;
    logic [IDX_W-1:0] park_number_q, park_number_d;
    logic             park_valid_q, park_valid_d;
    logic             park_full_q, park_full_d;
    logic [IDX_W:0]   free_count_q, free_count_d;

    logic             req;
    logic [IDX_W-1:0] free_idx;
    logic             found;
    logic [IDX_W:0]   zeros;

    free_slot_finder #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_finder (
        .occupancy (parking_capacity),
        .free_idx  (free_idx),
        .found     (found)
    );

    assign req = entry && !entry_q;

    always_comb begin
        zeros = '0;
        for (int i = 0; i < SLOTS; i++) begin
            zeros = zeros + {{IDX_W{1'b0}}, ~parking_capacity[i]};
        end
    end

    always_comb begin
        entry_d       = entry;
        park_valid_d  = req && found;
        park_number_d = (req && found) ? free_idx : park_number_q;
        park_full_d   = &parking_capacity;
        free_count_d  = zeros;
    end

    // Clearing entry_q in reset makes an entry held across release a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q       <= 1'b0;
            park_number_q <= '0;
            park_valid_q  <= 1'b0;
            park_full_q   <= 1'b0;
            free_count_q  <= '0;
        end else begin
            entry_q       <= entry_d;
            park_number_q <= park_number_d;
            park_valid_q  <= park_valid_d;
            park_full_q   <= park_full_d;
            free_count_q  <= free_count_d;
        end
    end

    assign park_number = park_number_q;
    assign park_valid  = park_valid_q;
    assign park_full   = park_full_q;
    assign free_count  = free_count_q;
endmodule

// File: tb/tb_entry_park.sv
// Bench for entry_park: table-driven vectors checked through an expectation queue,
// plus hand-written reset / held-entry / narrow-SLOTS sequences.
module tb_entry_park;
    typedef struct {
        logic       rst_n;
        logic       entry;
        logic [7:0] cap;
        logic       v;
        logic [2:0] num;
        logic       full;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        int         id;
        logic       v;
        logic [2:0] num;
        logic       full;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry = 1'b0;
    logic [7:0] cap = 8'h00;
    logic [2:0] park_number;
    logic       park_valid;
    logic       park_full;
    logic [3:0] free_count;

    logic       e5 = 1'b0;
    logic [4:0] cap5 = 5'h00;
    logic [2:0] num5;
    logic       v5;
    logic       full5;
    logic [3:0] cnt5;

    int n_cmp = 0;
    int n_bad = 0;
    int vec_id = 0;
    exp_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    entry_park #(.SLOTS(8), .IDX_W(3)) dut (
        .clk (clk), .rst_n (rst_n), .entry (entry), .parking_capacity (cap),
        .park_number (park_number), .park_valid (park_valid),
        .park_full (park_full), .free_count (free_count)
    );

    entry_park #(.SLOTS(5), .IDX_W(3)) dut5 (
        .clk (clk), .rst_n (rst_n), .entry (e5), .parking_capacity (cap5),
        .park_number (num5), .park_valid (v5),
        .park_full (full5), .free_count (cnt5)
    );

    task automatic check(input string nm, input int id, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and queue what the next rising edge must show.
    task automatic drive(input logic r, input logic e, input logic [7:0] c,
                         input logic v, input logic [2:0] n, input logic f, input logic [3:0] k);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        entry = e;
        cap   = c;
        x.id = vec_id; x.v = v; x.num = n; x.full = f; x.cnt = k;
        sb.push_back(x);
        vec_id++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("park_valid", x.id, int'(park_valid), int'(x.v));
            check("park_number", x.id, int'(park_number), int'(x.num));
            check("park_full", x.id, int'(park_full), int'(x.full));
            check("free_count", x.id, int'(free_count), int'(x.cnt));
        end
    end

    initial begin
        //          rst   ent   cap    v     num   full  cnt
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h15, 1'b0, 3'd0, 1'b0, 4'd5};
        tbl[2]  = '{1'b1, 1'b1, 8'h15, 1'b1, 3'd1, 1'b0, 4'd5};
        tbl[3]  = '{1'b1, 1'b0, 8'h15, 1'b0, 3'd1, 1'b0, 4'd5};
        tbl[4]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'd1, 1'b1, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h7F, 1'b0, 3'd1, 1'b0, 4'd1};
        tbl[6]  = '{1'b1, 1'b1, 8'h7F, 1'b1, 3'd7, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 4'd8};
        tbl[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 4'd8};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 4'd8};
        tbl[10] = '{1'b1, 1'b1, 8'hEF, 1'b1, 3'd4, 1'b0, 4'd1};
        tbl[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 3'd4, 1'b0, 4'd8};
        tbl[12] = '{1'b1, 1'b0, 8'h0F, 1'b0, 3'd4, 1'b0, 4'd4};

        for (int i = 0; i < 13; i++)
            drive(tbl[i].rst_n, tbl[i].entry, tbl[i].cap,
                  tbl[i].v, tbl[i].num, tbl[i].full, tbl[i].cnt);

        // Entry held high for five cycles: one assignment only.
        drive(1'b1, 1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 4'd7);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 8'h01, 1'b0, 3'd1, 1'b0, 4'd7);
        drive(1'b1, 1'b0, 8'h01, 1'b0, 3'd1, 1'b0, 4'd7);

        // Reset coinciding with a request edge, entry still high after release.
        drive(1'b0, 1'b1, 8'h03, 1'b0, 3'd0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 8'h03, 1'b1, 3'd2, 1'b0, 4'd6);
        drive(1'b1, 1'b1, 8'h03, 1'b0, 3'd2, 1'b0, 4'd6);
        drive(1'b1, 1'b0, 8'h03, 1'b0, 3'd2, 1'b0, 4'd6);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", -1, sb.size(), 0);

        // Narrow instance: SLOTS=5, indices 5..7 must never appear.
        @(negedge clk); e5 = 1'b0; cap5 = 5'h1F;
        @(negedge clk); e5 = 1'b1;
        @(posedge clk); #1;
        check("s5_full_valid", 100, int'(v5), 0);
        check("s5_full_flag", 100, int'(full5), 1);
        check("s5_full_cnt", 100, int'(cnt5), 0);
        check("s5_full_num", 100, int'(num5), 0);
        @(negedge clk); e5 = 1'b0; cap5 = 5'h0F;
        @(negedge clk); e5 = 1'b1;
        @(posedge clk); #1;
        check("s5_top_valid", 101, int'(v5), 1);
        check("s5_top_num", 101, int'(num5), 4);
        check("s5_top_cnt", 101, int'(cnt5), 1);
        check("s5_top_full", 101, int'(full5), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/entry_park.md
ENTRY_PARK -- requirements
Module: entry_park

Interface
- REQ-001: The block SHALL have parameter SLOTS, default 8, giving the number of parking slots.
- REQ-002: The block SHALL have parameter IDX_W, default 3, giving the slot index width; SLOTS SHALL be at most 2^IDX_W.
- REQ-003: The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset.
- REQ-005: The block SHALL have port entry, input, 1 bit, the car-at-gate request; it is level-sensitive and may be held high.
- REQ-006: The block SHALL have port parking_capacity, input, SLOTS bits, the occupancy map; bit i = 1 means slot i is occupied.
- REQ-007: The block SHALL have port park_number, output, IDX_W bits, the slot index most recently assigned.
- REQ-008: The block SHALL have port park_valid, output, 1 bit, a one-cycle pulse marking a new assignment in park_number.
- REQ-009: The block SHALL have port park_full, output, 1 bit, asserted when every slot is occupied.
- REQ-010: The block SHALL have port free_count, output, IDX_W+1 bits, the number of zero bits in parking_capacity.

Function
- REQ-011: The block SHALL register entry every cycle and detect a request as entry=1 in the current cycle with the registered entry=0.
- REQ-012: On a detected request with at least one free slot, the block SHALL load park_number with the lowest-index zero bit of parking_capacity at the next rising edge, and pulse park_valid high for exactly that one cycle.
- REQ-013: Latency from the request edge to park_valid SHALL be one clock cycle.
- REQ-014: On a detected request with no free slot, park_valid SHALL stay 0 and park_number SHALL hold its previous value.
- REQ-015: Holding entry high SHALL produce exactly one assignment; a new assignment requires entry to return to 0 for at least one cycle.
- REQ-016: park_number SHALL hold its value between assignments.
- REQ-017: park_full SHALL be registered and equal 1 exactly when every one of the SLOTS bits of parking_capacity was 1 at the previous edge.
- REQ-018: free_count SHALL be registered and equal the population count of zero bits of parking_capacity at the previous edge, in the range 0..SLOTS.
- REQ-019: The block SHALL sample parking_capacity in the same cycle as the request edge; later changes SHALL NOT alter the assignment already made.
- REQ-020: With SLOTS < 2^IDX_W, the block SHALL never assign any index at or above SLOTS.

Reset
- REQ-021: While rst_n=0 at a rising edge, park_number SHALL become 0, park_valid 0, park_full 0, free_count 0, and the registered entry 0.
- REQ-022: Reset SHALL override a concurrent request, with no park_valid pulse in that cycle.
- REQ-023: After reset is released, entry already high SHALL count as a new request edge.

Structure
- REQ-024: A shared package entry_park_pkg SHALL hold the default SLOTS and IDX_W constants.
- REQ-025: The lowest-free-slot priority encoder SHALL be a sub-module, free_slot_finder, which is combinational and outputs index plus found flag, parameterized by SLOTS and IDX_W.
- REQ-026: Popcount, edge detection and output registers SHALL reside in entry_park.

Verification
- REQ-027: parking_capacity=8'b00010101 with an entry 0->1 edge -> next cycle park_number=1, park_valid=1 for one cycle, free_count=5, park_full=0.
- REQ-028: parking_capacity=8'hFF with an entry edge -> park_valid stays 0, park_number unchanged, park_full=1, free_count=0.
- REQ-029: parking_capacity=8'h7F with an entry edge -> park_number=7, park_valid pulse; then 8'h00 with a fresh edge -> park_number=0.
- REQ-030: entry held high for 5 cycles with parking_capacity=8'h01 -> exactly one park_valid pulse, park_number=1.
- REQ-031: rst_n=0 asserted in the request-edge cycle with parking_capacity=8'h03 -> no park_valid pulse, all outputs 0; after release with entry still high -> park_number=2 with a valid pulse.
